// File: rtl/seq_divider_if.sv
// +--------------------------------------------------------------------+
// | seq_divider_if : request/result bundle between control and divider |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               sgn;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic               dbz;
  logic [2*WIDTH-1:0] q;

  modport master (output start, sgn, a, b, input busy, done, dbz, q);
  modport slave  (input start, sgn, a, b, output busy, done, dbz, q);
endinterface

`default_nettype wire

// File: rtl/seq_divider.sv
// +--------------------------------------------------------------------+
// | seq_divider : restoring divider, one quotient bit per clock.        |
// | Signed operation enabled by SEQ_DIVIDER_SIGNED_EN. Rev 1.0          |
// +--------------------------------------------------------------------+
`default_nettype none

module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH+1:0]   shifted, diff;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic a_neg, b_neg;

  assign a_neg   = bus.sgn & bus.a[WIDTH-1];
  assign b_neg   = bus.sgn & bus.b[WIDTH-1];
  assign a_mag   = a_neg ? -bus.a : bus.a;
  assign b_mag   = b_neg ? -bus.b : bus.b;
  assign quo_fix = qneg_q ? -quo_q : quo_q;
  assign rem_fix = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
`else
  assign a_mag   = bus.a;
  assign b_mag   = bus.b;
  assign quo_fix = quo_q;
  assign rem_fix = acc_q[WIDTH-1:0];
`endif

  // Trial subtract of the shifted partial remainder; the MSB of diff is the borrow.
  assign shifted = {acc_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {2'b00, dvs_q};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    res_d   = res_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          busy_d = 1'b1;
          acc_d  = '0;
          cnt_d  = CNT_W'(WIDTH - 1);
          dvs_d  = b_mag;
          dz_d   = (bus.b == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
`endif
          // On divide-by-zero the raw dividend is parked in quo for the remainder.
          if (bus.b == '0) begin
            quo_d   = bus.a;
            state_d = FIX;
          end else begin
            quo_d   = a_mag;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH+1]};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = dz_q;
        res_d   = dz_q ? {{WIDTH{1'b1}}, quo_q} : {quo_fix, rem_fix};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      res_q   <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      res_q   <= res_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;
  assign bus.q    = res_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// +--------------------------------------------------------------------+
// | tb_seq_divider : directed vectors for seq_divider, WIDTH = 32       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_seq_divider;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) dut_if ();

  seq_divider #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if.slave)
  );

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present operands at a falling edge; leaves time at 1 ns after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic hold);
    @(negedge clk);
    dut_if.start = 1'b1;
    dut_if.a     = a;
    dut_if.b     = b;
    dut_if.sgn   = s;
    @(posedge clk);
    #1;
    if (!hold) dut_if.start = 1'b0;
  endtask

  // Entered 1 ns after the accepting edge; returns 1 ns after the edge ending the done cycle.
  task automatic wait_res(input string tag, input logic [63:0] exp_q, input logic exp_dbz,
                          input int exp_lat, input int pulse_at, input logic keep);
    int cyc      = 0;
    int busy_cnt = 0;
    while (!dut_if.done && cyc < 100) begin
      if (dut_if.busy) busy_cnt++;
      @(posedge clk);
      #1;
      cyc++;
      if (pulse_at != 0 && cyc == pulse_at) begin
        dut_if.start = 1'b1;
        dut_if.a     = 32'd999;
        dut_if.b     = 32'd3;
        dut_if.sgn   = 1'b0;
      end
      if (pulse_at != 0 && cyc == pulse_at + 1) dut_if.start = keep;
    end
    check_vec({tag, ".lat"},  64'(cyc),      64'(exp_lat));
    check_vec({tag, ".busy"}, 64'(busy_cnt), 64'(exp_lat));
    check_vec({tag, ".bz"},   64'(dut_if.busy), 64'd0);
    check_vec({tag, ".q"},    dut_if.q,      exp_q);
    check_vec({tag, ".dbz"},  64'(dut_if.dbz), 64'(exp_dbz));
    @(posedge clk);
    #1;
    check_vec({tag, ".pulse"}, 64'(dut_if.done), 64'd0);
  endtask

  initial begin
    int nd;
    dut_if.start = 1'b0;
    dut_if.sgn   = 1'b0;
    dut_if.a     = '0;
    dut_if.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("rst.busy", 64'(dut_if.busy), 64'd0);
    check_vec("rst.done", 64'(dut_if.done), 64'd0);
    check_vec("rst.dbz",  64'(dut_if.dbz),  64'd0);
    check_vec("rst.q",    dut_if.q,         64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'd100, 32'd7, 1'b0, 1'b0);
    wait_res("u100_7", {32'd14, 32'd2}, 1'b0, LAT, 0, 1'b0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    issue(-32'sd100, 32'd7, 1'b1, 1'b0);
    wait_res("sn100_7", {32'hFFFF_FFF2, 32'hFFFF_FFFE}, 1'b0, LAT, 0, 1'b0);
    issue(32'd100, -32'sd7, 1'b1, 1'b0);
    wait_res("s100_n7", {32'hFFFF_FFF2, 32'd2}, 1'b0, LAT, 0, 1'b0);
`else
    issue(-32'sd100, 32'd7, 1'b1, 1'b0);
    wait_res("sn100_7", {32'h2492_4916, 32'd2}, 1'b0, LAT, 0, 1'b0);
    issue(32'd100, -32'sd7, 1'b1, 1'b0);
    wait_res("s100_n7", {32'd0, 32'd100}, 1'b0, LAT, 0, 1'b0);
`endif

    issue(32'd5, 32'd0, 1'b0, 1'b0);
    wait_res("dbz5", {32'hFFFF_FFFF, 32'd5}, 1'b1, 1, 0, 1'b0);
    issue(-32'sd5, 32'd0, 1'b1, 1'b0);
    wait_res("dbzn5", {32'hFFFF_FFFF, 32'hFFFF_FFFB}, 1'b1, 1, 0, 1'b0);
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    wait_res("dbzclr", {32'd14, 32'd2}, 1'b0, LAT, 0, 1'b0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_res("ovf", {32'h8000_0000, 32'd0}, 1'b0, LAT, 0, 1'b0);
`else
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_res("ovf", {32'd0, 32'h8000_0000}, 1'b0, LAT, 0, 1'b0);
`endif

    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    wait_res("max_1", {32'hFFFF_FFFF, 32'd0}, 1'b0, LAT, 0, 1'b0);
    issue(32'd7, 32'd100, 1'b0, 1'b0);
    wait_res("7_100", {32'd0, 32'd7}, 1'b0, LAT, 0, 1'b0);

    issue(32'd100, 32'd7, 1'b0, 1'b0);
    wait_res("midpulse", {32'd14, 32'd2}, 1'b0, LAT, 5, 1'b0);

    // start stays high; operands change mid-run and are taken in the done cycle
    issue(32'd1000000, 32'd1000, 1'b0, 1'b1);
    wait_res("b2b.1", {32'd1000, 32'd0}, 1'b0, LAT, 3, 1'b1);
    dut_if.start = 1'b0;
    wait_res("b2b.2", {32'd333, 32'd0}, 1'b0, LAT, 0, 1'b0);

    issue(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_vec("abort.busy", 64'(dut_if.busy), 64'd0);
    check_vec("abort.done", 64'(dut_if.done), 64'd0);
    check_vec("abort.dbz",  64'(dut_if.dbz),  64'd0);
    check_vec("abort.q",    dut_if.q,         64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (dut_if.done) nd++;
    end
    check_vec("abort.nodone", 64'(nd), 64'd0);
    issue(32'd12345, 32'd100, 1'b0, 1'b0);
    wait_res("recover", {32'd123, 32'd45}, 1'b0, LAT, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle restoring divider for the Mini SRC datapath's DIV instruction, replacing the single-cycle combinational array. One quotient bit is produced per clock. A start/busy/done handshake lets the control unit stall on the result. The block adds signed operation, divide-by-zero detection and operand capture. The result keeps the existing packing: quotient in the high half, remainder in the low half.

## Interface
- `WIDTH`, default 32: operand width in bits; must be at least 2.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a division; sampled only in IDLE.
- `sgn`, in, 1: 1 means the operands are two's-complement signed; 0 means unsigned. Captured together with `start`.
- `a`, in, WIDTH: dividend; captured on the accepting edge.
- `b`, in, WIDTH: divisor; captured on the accepting edge.
- `busy`, out, 1: high from the accepting edge until `done` rises.
- `done`, out, 1: one-cycle pulse when `q` and `dbz` are valid.
- `dbz`, out, 1: divide-by-zero flag for the most recent result.
- `q`, out, 2*WIDTH: result; `q[2*WIDTH-1:WIDTH]` is the quotient, `q[WIDTH-1:0]` is the remainder.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE → RUN** when `start` is 1.
  - Capture `sgn`, `a` and `b`.
  - Compute operand magnitudes (negate when signed and negative) and store them.
  - Store the quotient sign (sign of `a` XOR sign of `b`) and the remainder sign (sign of `a`).
  - Clear the WIDTH+1-bit partial remainder `A`.
  - Load the iteration counter with WIDTH-1.
  - Set `busy` = 1.
- **IDLE → FIX** when `start` is 1 and `b` = 0. RUN is skipped and the divide-by-zero path is flagged.
- **RUN**, once per cycle:
  - Shift `{A, Q}` left by one.
  - Trial-subtract `|b|` from `A`.
  - If the difference is negative, restore `A` and set `Q[0]` = 0; otherwise keep the difference and set `Q[0]` = 1.
  - When the counter reaches 0, go to FIX; otherwise decrement the counter.
- **FIX → IDLE**:
  - Apply sign correction: negate the quotient if the quotient sign is 1, and negate the remainder if the remainder sign is 1.
  - Register `q`, set `done` = 1, clear `busy`, update `dbz`.
- Semantics: truncating division, so the quotient rounds toward zero and the remainder takes the sign of the dividend.
- Divide by zero:
  - Quotient is all ones.
  - Remainder is the dividend `a` as captured, with no sign correction.
  - `dbz` = 1.
- Signed overflow (most-negative value / -1): quotient is the most-negative value (wraps), remainder is 0, `dbz` = 0. No extra logic is required; this falls out of magnitude arithmetic.
- `start` while `busy` is ignored; there is no queueing.
- `q` and `dbz` hold their values until the next FIX.
- `a`, `b` and `sgn` may change freely after the accepting edge.
- Arithmetic: magnitudes are WIDTH bits unsigned; `|MIN|` fits. The partial remainder is WIDTH+1 bits.

## Timing
- Edge E0 accepts `start`.
- Normal latency: `done` is high in the cycle following edge E(WIDTH+1), i.e. WIDTH+1 edges after acceptance. For WIDTH = 32, `done` is high after edge E33.
- Divide-by-zero latency: `done` is high after edge E1.
- `busy` is 1 from after E0 through the cycle before `done`. It is 0 in the `done` cycle.
- Back-to-back: `start` high during the `done` cycle is accepted, because the block is already in IDLE.
- Reset values: state IDLE, `busy` = 0, `done` = 0, `dbz` = 0, `q` = 0, and all internal registers 0.
- Reset mid-operation aborts immediately. No `done` is produced for the aborted operation.

## Configuration
- Macro: `SEQ_DIVIDER_SIGNED_EN`.
- Defined: `sgn` behaves as described, and the magnitude/negation logic is present.
- Undefined:
  - `sgn` is ignored and all operands are treated as unsigned.
  - Magnitude and negation logic is removed.
  - Latency, the divide-by-zero path and the handshake are unchanged.

## Test plan
- Unsigned, WIDTH = 32: `a` = 100, `b` = 7, `sgn` = 0 → `q` = {32'd14, 32'd2}. `done` is high after E33 only; `busy` is high for 33 cycles.
- Signed: `a` = -100, `b` = 7 → quotient -14, remainder -2. Then `a` = 100, `b` = -7 → quotient -14, remainder 2.
- Divide by zero: `a` = 5, `b` = 0 → quotient 0xFFFFFFFF, remainder 5, `dbz` = 1, `done` after E1. The next valid divide clears `dbz`.
- Overflow: `a` = 0x80000000, `b` = 0xFFFFFFFF, `sgn` = 1 → quotient 0x80000000, remainder 0, `dbz` = 0. With the macro undefined, the same inputs give quotient 0, remainder 0x80000000.
- Handshake:
  - `start` pulsed mid-RUN with different operands → ignored; the first result is unchanged.
  - `start` held through the `done` cycle → a second operation is accepted and completes WIDTH+1 edges later.
- Reset: assert `rst_n` = 0 at iteration 10 → all outputs are 0 immediately. No `done` follows, and a new `start` after release completes normally.
